// File: rtl/quant_post.sv
// Two-stage post-quantisation converter: an unsigned fixed-point magnitude with a
// block exponent is normalised into an IEEE-754 single. Stage 1 registers the
// operands and the leading-zero count; stage 2 registers the packed result.
// Results that underflow are flushed to signed zero and counted.
module quant_post #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic             i_sign,
    input  logic [7:0]       i_max_exp,
    input  logic [31:0]      i_activation,
    input  logic             i_clr,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [31:0]      o_fp32,
    output logic [CNT_W-1:0] o_flush_cnt
);

    logic             en1, en2;
    logic [4:0]       lz_d;
    logic             zero_d;

    logic             s1_valid_q;
    logic             s1_sign_q;
    logic [7:0]       s1_exp_q;
    logic [31:0]      s1_act_q;
    logic [4:0]       s1_lz_q;
    logic             s1_zero_q;

    logic             s2_valid_q;
    logic [31:0]      s2_fp32_q;
    logic [31:0]      res_d;
    logic             flush_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      norm;
    logic [8:0]       exp_s;

    // Handshake: a stage advances when it is empty or its successor advances.
    always_comb begin
        en2     = !s2_valid_q || o_ready;
        en1     = !s1_valid_q || en2;
        i_ready = en1;
    end

    // Leading-zero count of the incoming magnitude; the highest set bit wins.
    always_comb begin
        lz_d   = '0;
        zero_d = (i_activation == '0);
        for (int i = 0; i < 32; i++) begin
            if (i_activation[i]) begin
                lz_d = 5'(31 - i);
            end
        end
    end

    // Stage 1 operand register.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
        end else if (en1) begin
            s1_valid_q <= i_valid;
            s1_sign_q  <= i_sign;
            s1_exp_q   <= i_max_exp;
            s1_act_q   <= i_activation;
            s1_lz_q    <= lz_d;
            s1_zero_q  <= zero_d;
        end
    end

    // Normalise and pack; the leading one lands on bit 31 and is dropped (hidden bit).
    always_comb begin
        norm    = s1_act_q << s1_lz_q;
        exp_s   = {1'b0, s1_exp_q} - {4'b0000, s1_lz_q};
        flush_d = 1'b0;
        res_d   = {s1_sign_q, exp_s[7:0], norm[30:8]};
        if (s1_zero_q) begin
            res_d = {s1_sign_q, 31'd0};
        end else if (s1_exp_q == 8'hFF) begin
            res_d = {s1_sign_q, 8'hFF, 23'd0};
        end else if (exp_s[8] || (exp_s == 9'd0)) begin
            // No denormals: anything below the normal range becomes signed zero.
            res_d   = {s1_sign_q, 31'd0};
            flush_d = 1'b1;
        end
    end

    // Stage 2 result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_fp32_q  <= '0;
        end else if (en2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_fp32_q <= res_d;
            end
        end
    end

    // Flush counter: clear beats increment, saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (en2 && s1_valid_q && flush_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Flush counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_valid     = s2_valid_q;
    assign o_fp32      = s2_fp32_q;
    assign o_flush_cnt = cnt_q;

endmodule

// File: tb/tb_quant_post.sv
// Bench for quant_post: directed corner cases plus randomized traffic with random
// backpressure, checked every cycle against an arithmetic reference model.
module tb_quant_post;

    localparam int unsigned CW  = 4;
    localparam int unsigned MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid;
    logic          i_ready;
    logic          i_sign;
    logic [7:0]    i_max_exp;
    logic [31:0]   i_activation;
    logic          i_clr;
    logic          o_valid;
    logic          o_ready;
    logic [31:0]   o_fp32;
    logic [CW-1:0] o_flush_cnt;

    int nvec = 0;
    int nerr = 0;

    quant_post #(.CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (i_valid),
        .i_ready      (i_ready),
        .i_sign       (i_sign),
        .i_max_exp    (i_max_exp),
        .i_activation (i_activation),
        .i_clr        (i_clr),
        .o_valid      (o_valid),
        .o_ready      (o_ready),
        .o_fp32       (o_fp32),
        .o_flush_cnt  (o_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: {flushed, fp32} from plain arithmetic on the value a * 2^(x-158).
    function automatic logic [32:0] model(input logic s, input logic [7:0] x,
                                          input logic [31:0] a);
        int          p;
        int          e;
        logic [31:0] rem;
        logic [22:0] m;
        if (a == 0) return {1'b0, s, 31'd0};
        if (x == 8'hFF) return {1'b0, s, 8'hFF, 23'd0};
        p = 0;
        for (int i = 0; i < 32; i++) if (a[i]) p = i;
        e = int'(x) - (31 - p);
        if (e <= 0) return {1'b1, s, 31'd0};
        rem = a - (32'd1 << p);
        if (p >= 23) m = 23'(rem >> (p - 23));
        else m = 23'(rem << (23 - p));
        return {1'b0, s, 8'(e), m};
    endfunction

    // Scoreboard state owned by the compare process.
    logic [32:0] exp_q[$];
    logic [32:0] ew;
    int          mcnt     = 0;
    logic        pv       = 1'b0;
    logic        pr       = 1'b0;
    logic        clr_pend = 1'b0;
    logic        rst_pend = 1'b1;
    logic [31:0] last     = '0;
    logic        held, newword;

    // Compare process: sampled at the falling edge, inputs are stable here.
    always @(negedge clk) begin
        if (rst_pend) begin
            chk("reset_o_valid", {31'd0, o_valid}, 32'd0);
            chk("reset_o_fp32", o_fp32, 32'd0);
            chk("reset_flush_cnt", {28'd0, o_flush_cnt}, 32'd0);
            exp_q.delete();
            mcnt = 0;
        end else begin
            held    = pv && !pr;
            newword = o_valid && !held;
            if (held) begin
                chk("hold_valid", {31'd0, o_valid}, 32'd1);
                chk("hold_data", o_fp32, last);
            end
            if (newword) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL spurious_output: got %h expected no output at %0t",
                             o_fp32, $time);
                end else begin
                    ew = exp_q.pop_front();
                    chk("data", o_fp32, ew[31:0]);
                    if (ew[32] && !clr_pend && mcnt != MAX) mcnt++;
                end
                last = o_fp32;
            end
            if (clr_pend) mcnt = 0;
            chk("flush_cnt", {28'd0, o_flush_cnt}, 32'(mcnt));
        end
        if (i_valid && i_ready && !reset)
            exp_q.push_back(model(i_sign, i_max_exp, i_activation));
        pv       = o_valid;
        pr       = o_ready;
        clr_pend = i_clr;
        rst_pend = reset;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted (bounded).
    task automatic send(input logic s, input logic [7:0] x, input logic [31:0] a);
        logic r;
        int   t;
        i_valid      = 1'b1;
        i_sign       = s;
        i_max_exp    = x;
        i_activation = a;
        t = 0;
        do begin
            @(negedge clk);
            r = i_ready;
            step();
            t++;
        end while (!r && t < 50);
        if (!r) chk("send_timeout", 32'd0, 32'd1);
        i_valid = 1'b0;
    endtask

    logic [32:0] pin;
    logic        r;
    int          acc;
    int          c;

    initial begin
        reset        = 1'b1;
        i_valid      = 1'b0;
        i_sign       = 1'b0;
        i_max_exp    = '0;
        i_activation = '0;
        i_clr        = 1'b0;
        o_ready      = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, i_ready}, 32'd1);

        // Hand-computed values pinning the model.
        pin = model(1'b0, 8'h85, 32'h80000000); chk("pin_42800000", pin[31:0], 32'h42800000);
        pin = model(1'b0, 8'h85, 32'h00C00000); chk("pin_3EC00000", pin[31:0], 32'h3EC00000);
        pin = model(1'b0, 8'h05, 32'h00000100); chk("pin_flush", {pin[32], pin[31:0]} == 33'h1_00000000 ? 32'd1 : 32'd0, 32'd1);
        pin = model(1'b0, 8'h18, 32'h00000100); chk("pin_e1", {31'd0, pin[32]} | pin[31:0], 32'h00800000);
        pin = model(1'b1, 8'h40, 32'h00000000); chk("pin_negzero", pin[31:0], 32'h80000000);
        pin = model(1'b0, 8'hFF, 32'h00000001); chk("pin_inf", pin[31:0], 32'h7F800000);
        pin = model(1'b0, 8'h85, 32'hFF000000); chk("pin_sentinel", pin[31:0], 32'h42FF0000);

        // Directed words through the DUT.
        step();
        send(1'b0, 8'h85, 32'h80000000);
        send(1'b0, 8'h85, 32'h00C00000);
        send(1'b0, 8'h05, 32'h00000100);
        send(1'b0, 8'h18, 32'h00000100);
        send(1'b1, 8'h40, 32'h00000000);
        send(1'b0, 8'hFF, 32'h00000001);
        send(1'b1, 8'h85, 32'hFF000000);
        repeat (4) step();

        // Backpressure: o_ready low for three cycles against four back-to-back words.
        o_ready = 1'b0;
        acc = 0;
        c = 0;
        while (acc < 4 && c < 20) begin
            if (c == 3) o_ready = 1'b1;
            i_valid      = 1'b1;
            i_sign       = acc[0];
            i_max_exp    = 8'h80 + 8'(acc);
            i_activation = 32'h12345678 >> acc;
            @(negedge clk);
            r = i_ready;
            if (c == 2) begin
                chk("stall_accepted", 32'(acc), 32'd2);
                chk("stall_ready", {31'd0, r}, 32'd0);
            end
            step();
            if (r) acc++;
            c++;
        end
        i_valid = 1'b0;
        chk("stall_all_accepted", 32'(acc), 32'd4);
        o_ready = 1'b1;
        repeat (5) step();

        // Saturate the flush counter, then clear it during a flush.
        for (int k = 0; k < 16; k++) send(1'b0, 8'h01, 32'h00000001);
        repeat (4) step();
        @(negedge clk);
        chk("flush_saturated", {28'd0, o_flush_cnt}, MAX);
        step();
        i_clr = 1'b1;
        send(1'b1, 8'h02, 32'h00000010);
        step();
        i_clr = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("clr_over_inc", {28'd0, o_flush_cnt}, 32'd0);
        step();

        // Reset with two words in flight.
        send(1'b0, 8'h90, 32'h0000FFFF);
        send(1'b0, 8'h91, 32'h0000AAAA);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_flight_valid", {31'd0, o_valid}, 32'd0);
        repeat (6) step();

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 4000; k++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            o_ready = ($urandom_range(0, 9) < 7);
            i_clr   = ($urandom_range(0, 63) == 0);
            i_sign  = 1'($urandom);
            case ($urandom_range(0, 9))
                0:       i_activation = 32'd0;
                1:       i_activation = 32'hFF000000;
                default: i_activation = $urandom >> $urandom_range(0, 31);
            endcase
            case ($urandom_range(0, 9))
                0:       i_max_exp = 8'hFF;
                1, 2:    i_max_exp = 8'($urandom_range(0, 31));
                default: i_max_exp = 8'($urandom_range(0, 255));
            endcase
            step();
        end

        // Drain with a bounded wait.
        i_valid = 1'b0;
        i_clr   = 1'b0;
        o_ready = 1'b1;
        c = 0;
        while (exp_q.size() != 0 && c < 20) begin
            step();
            c++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/quant_post.md
QUANT_POST -- requirements
Module: quant_post

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the flush counter.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_valid  input  1  input word valid.
REQ-005 SHALL have port i_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port i_sign  input  1  sign to attach to the result.
REQ-007 SHALL have port i_max_exp  input  8  fp32 biased exponent that bit 31 of i_activation represents.
REQ-008 SHALL have port i_activation  input  32  unsigned fixed-point magnitude; value = i_activation * 2^(i_max_exp-127-31).
REQ-009 SHALL have port i_clr  input  1  clears o_flush_cnt.
REQ-010 SHALL have port o_valid  output  1  result valid.
REQ-011 SHALL have port o_ready  input  1  downstream accepts result.
REQ-012 SHALL have port o_fp32  output  32  IEEE-754 single result.
REQ-013 SHALL have port o_flush_cnt  output  CNT_W  count of results flushed to zero by underflow.

Function
REQ-014 SHALL transfer input when i_valid && i_ready and output when o_valid && o_ready.
REQ-015 SHALL be a 2-stage pipeline: S1 registers sign, max_exp, activation, leading-zero count lz (0..31) and zero flag; S2 registers o_fp32.
REQ-016 SHALL give latency 2 cycles from input transfer to o_valid with o_ready held high; throughput 1 word/cycle.
REQ-017 SHALL advance S2 when en2 = !s2_valid || o_ready, S1 when en1 = !s1_valid || en2, and drive i_ready = en1 (full backpressure, no data loss, no duplication).
REQ-018 SHALL hold o_fp32 and o_valid stable while o_valid && !o_ready.
REQ-019 SHALL, for i_activation == 0, output {i_sign, 31'd0} and not increment o_flush_cnt.
REQ-020 SHALL, for i_max_exp == 8'hFF and nonzero activation, output {i_sign, 8'hFF, 23'd0} (infinity).
REQ-021 SHALL otherwise compute e = i_max_exp - lz in 9-bit signed arithmetic.
REQ-022 SHALL, if e <= 0, output {i_sign, 31'd0} and increment o_flush_cnt (no denormals).
REQ-023 SHALL, if e >= 1, output {i_sign, e[7:0], m}, m = bits [31:9] of (i_activation << (lz+1)) in 32 bits; truncation, no rounding.
REQ-024 SHALL saturate o_flush_cnt at all-ones; increment occurs in the cycle the flushed word enters S2.
REQ-025 SHALL give i_clr priority over a same-cycle increment (counter becomes 0).
REQ-026 SHALL treat sentinel activation 32'hFF000000 as ordinary data (lz = 0, mantissa 7'h7F << 16).

Reset
REQ-027 SHALL, on reset high at a clk edge, set s1_valid = 0, o_valid = 0, o_fp32 = 0, o_flush_cnt = 0, regardless of in-flight data.
REQ-028 SHALL drive i_ready = 1 in the first cycle after reset deasserts.
REQ-029 SHALL discard words in flight when reset asserts mid-operation; none emerge afterwards.

Verification
REQ-030 SHALL pass: max_exp 8'h85, activation 32'h80000000, sign 0 -> o_fp32 32'h42800000 two cycles later.
REQ-031 SHALL pass: max_exp 8'h85, activation 32'h00C00000, sign 0 -> lz 8, o_fp32 32'h3EC00000.
REQ-032 SHALL pass: max_exp 8'h05, activation 32'h00000100 -> o_fp32 32'h00000000, o_flush_cnt +1; the same input with max_exp 8'h18 (e = 1) -> 32'h00800000, no increment.
REQ-033 SHALL pass: 4 back-to-back words with o_ready low for 3 cycles -> i_ready drops after 2 accepted, all 4 emerge in order, unchanged.
REQ-034 SHALL pass: activation 0 with sign 1 -> 32'h80000000; max_exp 8'hFF, activation 1 -> 32'h7F800000.
REQ-035 SHALL pass: o_flush_cnt preset to all-ones, one flush with i_clr in the same cycle -> counter reads 0; reset asserted with 2 words in flight -> o_valid 0 next cycle, no output.
